// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: round-robin front end that shares a single i2c_master
// transaction engine between NUM_REQ requesters, with a bus-hang watchdog.
module i2c_master_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int TIMEOUT_CYC = 200000,
   localparam int PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            req_mode,
   input  logic [NUM_REQ*7-1:0]          req_slave_addr,
   input  logic [NUM_REQ*8-1:0]          req_data_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
   output logic [NUM_REQ-1:0]            grant,
   output logic [NUM_REQ-1:0]            done,
   output logic [DATA_WIDTH-1:0]         rd_data,
   output logic                          busy,
   output logic                          timeout_err,
   output logic [PTR_W-1:0]              err_owner,
   input  logic                          err_clr,
   output logic                          m_start,
   output logic                          m_mode,
   output logic [6:0]                    m_slave_addr,
   output logic [7:0]                    m_data_addr,
   output logic [DATA_WIDTH-1:0]         m_data_in,
   input  logic [DATA_WIDTH-1:0]         m_data_out,
   input  logic                          m_data_rdy
);

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [PTR_W-1:0] LAST_IDX    = PTR_W'(NUM_REQ - 1);
   localparam logic [PTR_W:0]   NUM_REQ_EXT = (PTR_W + 1)'(NUM_REQ);

   typedef enum logic [2:0] {
      S_IDLE, S_ARB, S_LAUNCH, S_WAIT, S_DONE, S_ERR
   } state_t;

   state_t                  r_state;
   state_t                  w_nextState;
   logic [PTR_W-1:0]        r_rrPtr;
   logic [PTR_W-1:0]        r_winner;
   logic [CNT_W-1:0]        r_wdog;
   logic [NUM_REQ-1:0]      r_grant;
   logic [DATA_WIDTH-1:0]   r_rdData;
   logic                    r_timeoutErr;
   logic [PTR_W-1:0]        r_errOwner;
   logic                    r_mMode;
   logic [6:0]              r_mSlaveAddr;
   logic [7:0]              r_mDataAddr;
   logic [DATA_WIDTH-1:0]   r_mDataIn;
   logic                    w_found;
   logic [PTR_W-1:0]        w_winIdx;
   logic [PTR_W-1:0]        w_ptrNext;
   logic                    w_timeoutHit;

   // Folds rr_ptr+offset back into 0..NUM_REQ-1 without a divider.
   function automatic logic [PTR_W-1:0] wrapIdx(input logic [PTR_W:0] v);
      if (v >= NUM_REQ_EXT) return PTR_W'(v - NUM_REQ_EXT);
      else                  return v[PTR_W-1:0];
   endfunction

   assign w_ptrNext    = (r_winner == LAST_IDX) ? '0 : r_winner + 1'b1;
   assign w_timeoutHit = (r_wdog == TO_LAST);

   // Round-robin scan: first set req bit starting at rr_ptr and wrapping.
   always_comb begin
      w_found  = 1'b0;
      w_winIdx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_found && req[wrapIdx({1'b0, r_rrPtr} + (PTR_W + 1)'(i))]) begin
            w_found  = 1'b1;
            w_winIdx = wrapIdx({1'b0, r_rrPtr} + (PTR_W + 1)'(i));
         end
      end
   end

   // Next-state logic; m_data_rdy takes priority over the watchdog in WAIT.
   always_comb begin
      w_nextState = r_state;
      unique case (r_state)
         S_IDLE:   if (|req) w_nextState = S_ARB;
         S_ARB:    w_nextState = w_found ? S_LAUNCH : S_IDLE;
         S_LAUNCH: w_nextState = S_WAIT;
         S_WAIT: begin
            if (m_data_rdy)        w_nextState = S_DONE;
            else if (w_timeoutHit) w_nextState = S_ERR;
         end
         S_DONE:   w_nextState = S_IDLE;
         S_ERR:    if (err_clr) w_nextState = S_IDLE;
         default:  w_nextState = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_nextState;
   end

   // Datapath: winner latch, watchdog, read capture, pointer and error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rrPtr      <= '0;
         r_winner     <= '0;
         r_wdog       <= '0;
         r_grant      <= '0;
         r_rdData     <= '0;
         r_timeoutErr <= 1'b0;
         r_errOwner   <= '0;
         r_mMode      <= 1'b0;
         r_mSlaveAddr <= '0;
         r_mDataAddr  <= '0;
         r_mDataIn    <= '0;
      end else begin
         case (r_state)
            S_ARB: begin
               if (w_found) begin
                  r_winner     <= w_winIdx;
                  r_grant      <= NUM_REQ'(1) << w_winIdx;
                  r_mMode      <= req_mode[w_winIdx];
                  r_mSlaveAddr <= req_slave_addr[w_winIdx*7 +: 7];
                  r_mDataAddr  <= req_data_addr[w_winIdx*8 +: 8];
                  r_mDataIn    <= req_data_in[w_winIdx*DATA_WIDTH +: DATA_WIDTH];
               end
            end
            S_LAUNCH: r_wdog <= '0;
            S_WAIT: begin
               if (m_data_rdy) begin
                  r_rdData <= m_data_out;
               end else if (w_timeoutHit) begin
                  r_timeoutErr <= 1'b1;
                  r_errOwner   <= r_winner;
               end else begin
                  r_wdog <= r_wdog + 1'b1;
               end
            end
            S_DONE: begin
               r_rrPtr <= w_ptrNext;
               r_grant <= '0;
            end
            S_ERR: begin
               if (err_clr) begin
                  r_timeoutErr <= 1'b0;
                  r_grant      <= '0;
                  r_rrPtr      <= w_ptrNext;
               end
            end
            default: ;
         endcase
      end
   end

   assign grant        = r_grant;
   assign done         = (r_state == S_DONE) ? r_grant : '0;
   assign rd_data      = r_rdData;
   assign busy         = (r_state != S_IDLE);
   assign timeout_err  = r_timeoutErr;
   assign err_owner    = r_errOwner;
   assign m_start      = (r_state == S_LAUNCH);
   assign m_mode       = r_mMode;
   assign m_slave_addr = r_mSlaveAddr;
   assign m_data_addr  = r_mDataAddr;
   assign m_data_in    = r_mDataIn;

endmodule
